// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic signal controller: round-robin demand service with gap-out/max-out
// green timing, yellow/all-red clearance and emergency preemption.
module traffic_ctrl_multi #(
    parameter int unsigned N_APPR      = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned T_GREEN_MIN = 4,
    parameter int unsigned T_GREEN_MAX = 10,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_ALLRED    = 1,
    localparam int unsigned IDX_W      = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [N_APPR-1:0] C,
    input  logic              Emergency,
    input  logic [IDX_W-1:0]  EmDir,
    output logic [N_APPR-1:0] R,
    output logic [N_APPR-1:0] Y,
    output logic [N_APPR-1:0] G,
    output logic              ST,
    output logic              EmAck,
    output logic [IDX_W-1:0]  Cur
);

    typedef enum logic [1:0] {StGreen, StYellow, StAllRed, StEmGreen} state_e;

    localparam logic [IDX_W:0]   N_APPR_W = (IDX_W + 1)'(N_APPR);
    localparam logic [CNT_W-1:0] GMIN_T   = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_T   = CNT_W'(T_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_T    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_T     = CNT_W'(T_ALLRED - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [N_APPR-1:0]   req_q, req_d;
    logic [N_APPR-1:0]   cur_mask, next_mask;
    logic [N_APPR-1:0]   g_d, y_d;
    logic [IDX_W-1:0]    rr_next;
    logic                em_valid, conflict, enter;

    // (base + k) mod N_APPR for k <= N_APPR, without a divider.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned k);
        logic [IDX_W:0] s;
        s = {1'b0, base} + (IDX_W + 1)'(k);
        if (s >= N_APPR_W) s = s - N_APPR_W;
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        em_valid = Emergency && ({1'b0, EmDir} < N_APPR_W);

        cur_mask        = '0;
        cur_mask[cur_q] = 1'b1;
        conflict        = |(req_q & ~cur_mask);

        // Scan from the far end so the nearest requesting approach wins.
        rr_next = wrap_add(cur_q, 1);
        for (int unsigned k = N_APPR; k >= 1; k--) begin
            if (req_q[wrap_add(cur_q, k)]) rr_next = wrap_add(cur_q, k);
        end

        state_d = state_q;
        cur_d   = cur_q;
        unique case (state_q)
            StGreen: begin
                if (em_valid && EmDir == cur_q) begin
                    state_d = StEmGreen;
                end else if (em_valid) begin
                    state_d = StYellow;
                end else if (conflict && ((timer_q >= GMIN_T && !C[cur_q]) ||
                                          timer_q >= GMAX_T)) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (timer_q == YEL_T) state_d = StAllRed;
            end
            StAllRed: begin
                if (timer_q == AR_T) begin
                    if (em_valid) begin
                        state_d = StEmGreen;
                        cur_d   = EmDir;
                    end else begin
                        state_d = StGreen;
                        cur_d   = rr_next;
                    end
                end
            end
            StEmGreen: begin
                if (!em_valid) begin
                    state_d = StGreen;
                end else if (EmDir != cur_q) begin
                    state_d = StYellow;
                end
            end
            default: state_d = StGreen;
        endcase

        enter   = (state_d != state_q);
        timer_d = enter ? '0 : ((timer_q == '1) ? timer_q : timer_q + CNT_W'(1));

        next_mask        = '0;
        next_mask[cur_d] = 1'b1;

        // Entering service clears the served approach even if its sensor is active now.
        req_d = req_q | C;
        if (enter && (state_d == StGreen || state_d == StEmGreen)) req_d[cur_d] = 1'b0;

        g_d = (state_d == StGreen || state_d == StEmGreen) ? next_mask : '0;
        y_d = (state_d == StYellow) ? next_mask : '0;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= StGreen;
            cur_q   <= '0;
            timer_q <= '0;
            req_q   <= '0;
            G       <= N_APPR'(1);
            Y       <= '0;
            R       <= ~N_APPR'(1);
            ST      <= 1'b0;
            EmAck   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            G       <= g_d;
            Y       <= y_d;
            R       <= ~(g_d | y_d);
            ST      <= enter;
            EmAck   <= (state_d == StEmGreen);
        end
    end

    assign Cur = cur_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Scoreboard bench for traffic_ctrl_multi: cycle-stamped expected lamp states are queued by the
// stimulus thread and checked by an independent monitor each cycle.
module tb_traffic_ctrl_multi;

    localparam int K_G  = 0;
    localparam int K_Y  = 1;
    localparam int K_AR = 2;
    localparam int K_EM = 3;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] C = '0;
    logic       Emergency = 1'b0;
    logic [1:0] EmDir = '0;
    logic [3:0] R, Y, G;
    logic       ST, EmAck;
    logic [1:0] Cur;

    traffic_ctrl_multi dut (
        .Clk       (Clk),
        .reset     (reset),
        .C         (C),
        .Emergency (Emergency),
        .EmDir     (EmDir),
        .R         (R),
        .Y         (Y),
        .G         (G),
        .ST        (ST),
        .EmAck     (EmAck),
        .Cur       (Cur)
    );

    always #5 Clk = ~Clk;

    // Cycle 0 is the first cycle after the last reset edge.
    int cyc = 0;
    always @(posedge Clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int         cyc;
        logic       st;
        logic [3:0] g, y, r;
        logic [1:0] cur;
        logic       em;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic push_exp(input int c, input int kind, input int cur, input logic st);
        exp_t       e;
        logic [3:0] m;
        m     = 4'b0001 << cur;
        e.cyc = c;
        e.st  = st;
        e.cur = 2'(cur);
        e.em  = (kind == K_EM);
        e.g   = (kind == K_G || kind == K_EM) ? m : 4'b0000;
        e.y   = (kind == K_Y) ? m : 4'b0000;
        e.r   = ~(e.g | e.y);
        exp_q.push_back(e);
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge Clk) begin
        exp_t        e;
        int          nonred;
        logic        ok;
        logic [15:0] got, want;
        if (!reset) begin
            ok     = 1'b1;
            nonred = 0;
            for (int i = 0; i < 4; i++) begin
                if ((32'(R[i]) + 32'(Y[i]) + 32'(G[i])) != 1) ok = 1'b0;
                if (!R[i]) nonred++;
            end
            if (nonred > 1) ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL lamp_onehot cyc=%0d got R=%b Y=%b G=%b, required one-hot per approach and <=1 non-red",
                         cyc, R, Y, G);
            end

            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missed_check cyc=%0d expected entry was never sampled", e.cyc);
            end

            got = {ST, G, Y, R, Cur, EmAck};
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e    = exp_q.pop_front();
                want = {e.st, e.g, e.y, e.r, e.cur, e.em};
                n_vec++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL state cyc=%0d got ST=%b G=%b Y=%b R=%b Cur=%0d EmAck=%b, required ST=%b G=%b Y=%b R=%b Cur=%0d EmAck=%b",
                             cyc, ST, G, Y, R, Cur, EmAck, e.st, e.g, e.y, e.r, e.cur, e.em);
                end
            end else begin
                n_vec++;
                if (ST !== 1'b0) begin
                    n_bad++;
                    $display("FAIL unexpected_st cyc=%0d got ST=%b, required 0", cyc, ST);
                end
            end
        end
    end

    // Returns #1 after the negedge of cycle n (inputs then apply to the edge ending cycle n).
    task automatic at_cyc(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
        end while (cyc != n && guard < 200);
        if (cyc != n) begin
            n_vec++;
            n_bad++;
            $display("FAIL at_cyc_timeout got cyc=%0d, required %0d", cyc, n);
            $fatal(1, "cycle wait expired");
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        reset     = 1'b0;
        C         = '0;
        Emergency = 1'b0;
        EmDir     = '0;
    endtask

    initial begin
        // Idle: rest on approach 0, no ST.
        do_reset();
        push_exp(0, K_G, 0, 1'b0);
        push_exp(10, K_G, 0, 1'b0);
        push_exp(25, K_G, 0, 1'b0);
        push_exp(49, K_G, 0, 1'b0);
        at_cyc(50);

        // Single pulse on approach 2: gap-out, yellow 2, all-red 1, serve 2.
        do_reset();
        push_exp(0, K_G, 0, 1'b0);
        push_exp(11, K_G, 0, 1'b0);
        push_exp(12, K_Y, 0, 1'b1);
        push_exp(13, K_Y, 0, 1'b0);
        push_exp(14, K_AR, 0, 1'b1);
        push_exp(15, K_G, 2, 1'b1);
        push_exp(16, K_G, 2, 1'b0);
        push_exp(20, K_G, 2, 1'b0);
        at_cyc(10); C = 4'b0100;
        at_cyc(11); C = 4'b0000;
        at_cyc(21);

        // Max-out with approach 0 occupied, then gap-out back to 0.
        do_reset();
        push_exp(0, K_G, 0, 1'b0);
        push_exp(9, K_G, 0, 1'b0);
        push_exp(10, K_Y, 0, 1'b1);
        push_exp(11, K_Y, 0, 1'b0);
        push_exp(12, K_AR, 0, 1'b1);
        push_exp(13, K_G, 1, 1'b1);
        push_exp(16, K_G, 1, 1'b0);
        push_exp(17, K_Y, 1, 1'b1);
        push_exp(18, K_Y, 1, 1'b0);
        push_exp(19, K_AR, 1, 1'b1);
        push_exp(20, K_G, 0, 1'b1);
        push_exp(22, K_G, 0, 1'b0);
        at_cyc(0);  C = 4'b0011;
        at_cyc(1);  C = 4'b0001;
        at_cyc(22); C = 4'b0000;
        at_cyc(23);

        // Round-robin from Cur=2 with demand on 1 and 3: serve 3, then 1.
        do_reset();
        push_exp(0, K_G, 0, 1'b0);
        push_exp(12, K_Y, 0, 1'b1);
        push_exp(14, K_AR, 0, 1'b1);
        push_exp(15, K_G, 2, 1'b1);
        push_exp(19, K_Y, 2, 1'b1);
        push_exp(20, K_Y, 2, 1'b0);
        push_exp(21, K_AR, 2, 1'b1);
        push_exp(22, K_G, 3, 1'b1);
        push_exp(25, K_G, 3, 1'b0);
        push_exp(26, K_Y, 3, 1'b1);
        push_exp(28, K_AR, 3, 1'b1);
        push_exp(29, K_G, 1, 1'b1);
        push_exp(32, K_G, 1, 1'b0);
        at_cyc(10); C = 4'b0100;
        at_cyc(11); C = 4'b0000;
        at_cyc(17); C = 4'b1010;
        at_cyc(18); C = 4'b0000;
        at_cyc(33);

        // Emergency to 3 during early green on 0: immediate yellow, then EM_GREEN, then GREEN.
        do_reset();
        push_exp(0, K_G, 0, 1'b0);
        push_exp(1, K_G, 0, 1'b0);
        push_exp(2, K_Y, 0, 1'b1);
        push_exp(3, K_Y, 0, 1'b0);
        push_exp(4, K_AR, 0, 1'b1);
        push_exp(5, K_EM, 3, 1'b1);
        push_exp(7, K_EM, 3, 1'b0);
        push_exp(9, K_EM, 3, 1'b0);
        push_exp(10, K_G, 3, 1'b1);
        push_exp(12, K_G, 3, 1'b0);
        at_cyc(1); Emergency = 1'b1; EmDir = 2'd3;
        at_cyc(9); Emergency = 1'b0;
        at_cyc(13);

        // Emergency on current approach, redirect, then reset during EM_GREEN.
        do_reset();
        push_exp(2, K_G, 0, 1'b0);
        push_exp(3, K_EM, 0, 1'b1);
        push_exp(5, K_EM, 0, 1'b0);
        push_exp(6, K_Y, 0, 1'b1);
        push_exp(7, K_Y, 0, 1'b0);
        push_exp(8, K_AR, 0, 1'b1);
        push_exp(9, K_EM, 2, 1'b1);
        push_exp(10, K_EM, 2, 1'b0);
        at_cyc(2); Emergency = 1'b1; EmDir = 2'd0;
        at_cyc(3); C = 4'b0010;
        at_cyc(4); C = 4'b0000;
        at_cyc(5); EmDir = 2'd2;
        at_cyc(11);
        do_reset();
        // A pending request on 1 surviving reset would force a yellow by cycle 4.
        push_exp(0, K_G, 0, 1'b0);
        push_exp(8, K_G, 0, 1'b0);
        at_cyc(9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion, required summary before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
